// File: rtl/imc_wb_host_loader.sv
// imc_wb_host_loader
// Flow-controlled Wishbone-side initiator for the IMC buffer interface.
// Write commands (IM/IB/WB) stream words from wr_* onto the IMC bus, one bus
// cycle per accepted word. Read commands (SA/OB) fetch entries from the IMC
// readback bus and present them on rd_* with a valid/ready handshake.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake; cmd_op/cmd_base/cmd_count
//   wr_valid/wr_ready/wr_data   write-data stream
//   rd_valid/rd_ready/rd_data   readback stream, rd_last on the final entry
//   wbs_we_o/wb_addr_o/wb_data_o  registered IMC bus drive
//   wb_data_i                   IMC readback bus
//   busy, done, err             status (done/err are one-cycle pulses)
module imc_wb_host_loader #(
  parameter logic [7:0]  CODE_IM   = 8'h01,
  parameter logic [7:0]  CODE_IB   = 8'h02,
  parameter logic [7:0]  CODE_WB   = 8'h03,
  parameter logic [7:0]  CODE_SA   = 8'h04,
  parameter logic [7:0]  CODE_OB   = 8'h05,
  parameter logic [7:0]  CODE_IDLE = 8'h00,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [5:0]  cmd_base,
  input  logic [6:0]  cmd_count,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [63:0] rd_data,
  output logic        rd_last,
  output logic        wbs_we_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, RD_OUT} state_t;

  localparam logic [1:0]  LAT       = 2'(RD_LAT);
  localparam logic [31:0] ADDR_IDLE = {CODE_IDLE, 24'h0};
  localparam logic [2:0]  SEL_OB_LO = 3'b001;
  localparam logic [2:0]  SEL_OB_HI = 3'b010;
  localparam logic [2:0]  SEL_SA    = 3'b100;

  state_t      state;
  logic [7:0]  code;
  logic        is_im;
  logic        is_ob;
  logic        hi_phase;
  logic [5:0]  idx;
  logic [6:0]  remaining;
  logic [1:0]  wait_cnt;
  logic [31:0] lo_word;

  logic [5:0]  idx_next;
  logic [7:0]  cmd_code;
  logic        cmd_im;
  logic        cmd_legal;
  logic [5:0]  cmd_idx;
  logic [2:0]  cmd_sel;

  function automatic logic [31:0] bus_addr(input logic [7:0] c, input logic [2:0] sel,
                                           input logic [5:0] i);
    return {c, 2'b00, sel, 13'b0, i};
  endfunction

  // Index wraps at the depth of the active buffer (64 for IM, 16 otherwise).
  assign idx_next = (idx + 6'd1) & (is_im ? 6'h3F : 6'h0F);

  always_comb begin
    cmd_code = CODE_IDLE;
    case (cmd_op)
      3'd0:    cmd_code = CODE_IM;
      3'd1:    cmd_code = CODE_IB;
      3'd2:    cmd_code = CODE_WB;
      3'd3:    cmd_code = CODE_SA;
      3'd4:    cmd_code = CODE_OB;
      default: cmd_code = CODE_IDLE;
    endcase
    cmd_im    = (cmd_op == 3'd0);
    cmd_legal = (cmd_op <= 3'd4) && (cmd_count != 7'd0) &&
                (cmd_count <= (cmd_im ? 7'd64 : 7'd16));
    cmd_idx   = cmd_im ? cmd_base : {2'b00, cmd_base[3:0]};
    cmd_sel   = (cmd_op == 3'd3) ? SEL_SA : SEL_OB_LO;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      code      <= CODE_IDLE;
      is_im     <= 1'b0;
      is_ob     <= 1'b0;
      hi_phase  <= 1'b0;
      idx       <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      lo_word   <= '0;
      wbs_we_o  <= 1'b0;
      wb_addr_o <= ADDR_IDLE;
      wb_data_o <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (!cmd_legal) begin
              err <= 1'b1;
            end else begin
              code      <= cmd_code;
              is_im     <= cmd_im;
              is_ob     <= (cmd_op == 3'd4);
              idx       <= cmd_idx;
              remaining <= cmd_count;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              if (cmd_op <= 3'd2) begin
                state    <= WRITE;
                wr_ready <= 1'b1;
              end else begin
                state     <= RD_ADDR;
                hi_phase  <= 1'b0;
                wb_addr_o <= bus_addr(cmd_code, cmd_sel, cmd_idx);
              end
            end
          end
        end
        WRITE: begin
          if (remaining == 7'd0) begin
            // Last word's bus cycle has just been driven.
            wbs_we_o  <= 1'b0;
            wb_addr_o <= ADDR_IDLE;
            wb_data_o <= '0;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else if (wr_valid && wr_ready) begin
            wbs_we_o  <= 1'b1;
            wb_addr_o <= bus_addr(code, 3'b000, idx);
            wb_data_o <= is_im ? wr_data : {16'h0, wr_data[15:0]};
            idx       <= idx_next;
            remaining <= remaining - 7'd1;
            if (remaining == 7'd1) wr_ready <= 1'b0;
          end else begin
            wbs_we_o  <= 1'b0;
            wb_addr_o <= ADDR_IDLE;
            wb_data_o <= '0;
          end
        end
        RD_ADDR: begin
          state    <= RD_WAIT;
          wait_cnt <= 2'd1;
        end
        RD_WAIT: begin
          if (wait_cnt == LAT) begin
            if (is_ob && !hi_phase) begin
              lo_word   <= wb_data_i;
              hi_phase  <= 1'b1;
              wb_addr_o <= bus_addr(code, SEL_OB_HI, idx);
              state     <= RD_ADDR;
            end else begin
              rd_data   <= is_ob ? {wb_data_i, lo_word} : {48'h0, wb_data_i[15:0]};
              rd_valid  <= 1'b1;
              rd_last   <= (remaining == 7'd1);
              wb_addr_o <= ADDR_IDLE;
              state     <= RD_OUT;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        RD_OUT: begin
          if (rd_ready) begin
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            idx       <= idx_next;
            remaining <= remaining - 7'd1;
            if (remaining == 7'd1) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              hi_phase  <= 1'b0;
              wb_addr_o <= bus_addr(code, is_ob ? SEL_OB_LO : SEL_SA, idx_next);
              state     <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imc_wb_host_loader.sv
// Directed testbench for imc_wb_host_loader with a one-cycle-latency IMC
// readback model and hand-computed expected bus/readback values.
module tb_imc_wb_host_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [5:0]  cmd_base;
  logic [6:0]  cmd_count;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        wbs_we_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i = 32'h0;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  imc_wb_host_loader #(.RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .wbs_we_o(wbs_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_data_i(wb_data_i), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // IMC readback: data for the address seen at an edge is valid one cycle later.
  function automatic logic [31:0] imc_model(input logic [31:0] a);
    case (a)
      32'h0508_0003: return 32'h1111_2222;
      32'h0510_0003: return 32'h3333_4444;
      32'h0508_0004: return 32'h5555_6666;
      32'h0510_0004: return 32'h7777_8888;
      32'h0420_0005: return 32'hBEEF_C3A5;
      default:       return 32'hDEAD_DEAD;
    endcase
  endfunction

  always @(posedge clk) wb_data_i <= imc_model(wb_addr_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] data);
    check({tag, ".we"}, {63'h0, wbs_we_o}, {63'h0, we});
    check({tag, ".addr"}, {32'h0, wb_addr_o}, {32'h0, addr});
    check({tag, ".data"}, {32'h0, wb_data_o}, {32'h0, data});
  endtask

  // {cmd_ready, busy, done, err, wr_ready, rd_valid, rd_last}
  task automatic check_status(input string tag, input logic [6:0] exp);
    check({tag, ".status"}, {57'h0, cmd_ready, busy, done, err, wr_ready, rd_valid, rd_last},
          {57'h0, exp});
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] base, input logic [6:0] count);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = base;
    cmd_count = count;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [31:0] ib_data [4];
  logic [5:0]  ib_idx  [4];
  logic [2:0]  bad_op  [4];
  logic [6:0]  bad_cnt [4];

  initial begin
    ib_data = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    ib_idx  = '{6'd14, 6'd15, 6'd0, 6'd1};
    bad_op  = '{3'd6, 3'd0, 3'd1, 3'd2};
    bad_cnt = '{7'd1, 7'd65, 7'd0, 7'd17};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_base = '0; cmd_count = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_bus("reset", 1'b0, 32'h0, 32'h0);
    check("reset.rd_data", rd_data, 64'h0);
    check_status("reset", 7'b1000000);

    // IB write, base 14, count 4: index wraps 15 -> 0
    wr_valid = 1'b1;
    wr_data  = ib_data[0];
    issue(3'd1, 6'd14, 7'd4);
    check_status("ib_start", 7'b0100100);
    check_bus("ib_start", 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bus($sformatf("ib_word%0d", i), 1'b1, {8'h02, 18'h0, ib_idx[i]}, ib_data[i]);
      check($sformatf("ib_word%0d.done", i), {63'h0, done}, 64'h0);
      if (i < 3) wr_data = ib_data[i+1];
    end
    check("ib_wr_ready_drop", {63'h0, wr_ready}, 64'h0);
    wr_valid = 1'b0;
    tick();
    check_status("ib_done", 7'b1010000);
    check_bus("ib_done", 1'b0, 32'h0, 32'h0);
    tick();
    check("ib_done_pulse", {63'h0, done}, 64'h0);

    // OB read, base 3, count 2
    issue(3'd4, 6'd3, 7'd2);
    check_bus("ob0_lo_addr", 1'b0, 32'h0508_0003, 32'h0);
    check_status("ob_start", 7'b0100000);
    tick();
    check("ob0_lo_hold", {32'h0, wb_addr_o}, {32'h0, 32'h0508_0003});
    tick();
    check("ob0_hi_addr", {32'h0, wb_addr_o}, {32'h0, 32'h0510_0003});
    tick();
    check("ob0_hi_hold", {32'h0, wb_addr_o}, {32'h0, 32'h0510_0003});
    tick();
    check("ob0_rd_data", rd_data, 64'h3333_4444_1111_2222);
    check_status("ob0_out", 7'b0100010);
    check_bus("ob0_out", 1'b0, 32'h0, 32'h0);
    rd_ready = 1'b1;
    tick();
    check("ob1_lo_addr", {32'h0, wb_addr_o}, {32'h0, 32'h0508_0004});
    check("ob1_rd_valid", {63'h0, rd_valid}, 64'h0);
    tick();
    tick();
    check("ob1_hi_addr", {32'h0, wb_addr_o}, {32'h0, 32'h0510_0004});
    tick();
    tick();
    check("ob1_rd_data", rd_data, 64'h7777_8888_5555_6666);
    check_status("ob1_out", 7'b0100011);
    tick();
    check_status("ob_done", 7'b1010000);
    rd_ready = 1'b0;

    // SA read, count 1, with back-pressure
    issue(3'd3, 6'd5, 7'd1);
    check("sa_addr", {32'h0, wb_addr_o}, {32'h0, 32'h0420_0005});
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sa_stall%0d.data", i), rd_data, 64'h0000_0000_0000_C3A5);
      check_status($sformatf("sa_stall%0d", i), 7'b0100011);
      check_bus($sformatf("sa_stall%0d", i), 1'b0, 32'h0, 32'h0);
      tick();
    end
    rd_ready = 1'b1;
    tick();
    check_status("sa_done", 7'b1010000);
    rd_ready = 1'b0;

    // Illegal commands
    for (int i = 0; i < 4; i++) begin
      issue(bad_op[i], 6'd0, bad_cnt[i]);
      check_status($sformatf("bad%0d", i), 7'b1001000);
      check_bus($sformatf("bad%0d", i), 1'b0, 32'h0, 32'h0);
      tick();
      check_status($sformatf("bad%0d_after", i), 7'b1000000);
    end

    // Reset during the second word of a WB burst
    wr_valid = 1'b1;
    wr_data  = 32'hB1;
    issue(3'd2, 6'd0, 7'd4);
    tick();
    check_bus("wb_word0", 1'b1, 32'h0300_0000, 32'hB1);
    wr_data = 32'hB2;
    reset   = 1'b1;
    tick();
    reset    = 1'b0;
    wr_valid = 1'b0;
    check_bus("wb_reset", 1'b0, 32'h0, 32'h0);
    check_status("wb_reset", 7'b1000000);
    tick();
    check_status("wb_reset_after", 7'b1000000);

    // IM write after reset: wrap 63 -> 0, full 32-bit data, one wr_valid gap
    wr_valid = 1'b1;
    wr_data  = 32'h1234_5678;
    issue(3'd0, 6'd63, 7'd2);
    tick();
    check_bus("im_word0", 1'b1, 32'h0100_003F, 32'h1234_5678);
    wr_valid = 1'b0;
    tick();
    check_bus("im_gap", 1'b0, 32'h0, 32'h0);
    wr_valid = 1'b1;
    wr_data  = 32'h9ABC_DEF0;
    tick();
    check_bus("im_word1", 1'b1, 32'h0100_0000, 32'h9ABC_DEF0);
    wr_valid = 1'b0;
    tick();
    check_status("im_done", 7'b1010000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
